// File: rtl/io_bus_arbiter_pkg.sv
// Shared types and constants for the two-master IO bus arbiter.
// Holds the FSM state encoding, IO register map and default widths.
package io_arb_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} arb_state_t;

    localparam logic [1:0] IO_STATUS = 2'b00;
    localparam logic [1:0] IO_LED    = 2'b01;
    localparam logic [1:0] IO_SW_LO  = 2'b10;
    localparam logic [1:0] IO_SW_HI  = 2'b11;

    localparam int ADDR_W_DEF  = 2;
    localparam int WDATA_W_DEF = 12;
    localparam int RDATA_W_DEF = 32;

    // Per-master strobe vector: bit idx set when en is high.
    function automatic logic [1:0] onehot2(input logic en, input logic idx);
        logic [1:0] v;
        v = 2'b00;
        if (en) v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/io_bus_arbiter_if.sv
// Bundle of both master handshakes plus the IO peripheral port.
// arb is the arbiter view; master and slave are the two sides it connects.
interface io_bus_arbiter_if #(
    parameter int ADDR_W  = 2,
    parameter int WDATA_W = 12,
    parameter int RDATA_W = 32
);
    logic               m0_req,   m1_req;
    logic               m0_we,    m1_we;
    logic [ADDR_W-1:0]  m0_addr,  m1_addr;
    logic [WDATA_W-1:0] m0_wdata, m1_wdata;
    logic               m0_gnt,   m1_gnt;
    logic               m0_done,  m1_done;
    logic [RDATA_W-1:0] rdata;

    logic               pread;
    logic               pwrite;
    logic [ADDR_W-1:0]  addr;
    logic [WDATA_W-1:0] pwritedata;
    logic [RDATA_W-1:0] preaddata;

    modport arb (
        input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
        output m0_gnt, m1_gnt, m0_done, m1_done, rdata,
        output pread, pwrite, addr, pwritedata,
        input  preaddata
    );

    modport master (
        output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
        input  m0_gnt, m1_gnt, m0_done, m1_done, rdata
    );

    modport slave (
        input  pread, pwrite, addr, pwritedata,
        output preaddata
    );
endinterface

// File: rtl/io_bus_arbiter_rr_pick.sv
// Combinational two-requester picker: round-robin on last_owner or fixed m0 priority.
// Kept separate so a wider N-master version can slot in later.
import io_arb_pkg::*;

module rr_pick (
    input  logic [1:0] req,
    input  logic       last_owner,
    input  logic       fair,
    output logic       valid,
    output logic       winner
);
    always_comb begin
        valid  = |req;
        winner = 1'b0;
        if (req == 2'b10)
            winner = 1'b1;
        else if (req == 2'b11)
            winner = fair ? ~last_owner : 1'b0;
    end
endmodule

// File: rtl/io_bus_arbiter.sv
// Serialises two masters onto the single IO peripheral port with an IDLE/ACCESS/DONE FSM.
// Request fields are latched at acceptance; all outputs come from registers or state/owner.
import io_arb_pkg::*;

module io_bus_arbiter #(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int WDATA_W    = WDATA_W_DEF,
    parameter int RDATA_W    = RDATA_W_DEF,
    parameter int ACC_CYCLES = 1,
    parameter bit FAIR       = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    io_bus_arbiter_if.arb  bus
);
    localparam int CNT_W = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;

    typedef struct packed {
        logic               we;
        logic [ADDR_W-1:0]  addr;
        logic [WDATA_W-1:0] wdata;
    } acc_t;

    arb_state_t         state;
    logic               owner;
    logic               last_owner;
    logic [CNT_W-1:0]   cnt;
    acc_t               acc_q;
    logic [RDATA_W-1:0] rdata_q;

    logic               pick_valid;
    logic               pick_winner;
    logic [1:0]         gnt_v;
    logic [1:0]         done_v;

    rr_pick u_pick (
        .req        ({bus.m1_req, bus.m0_req}),
        .last_owner (last_owner),
        .fair       (FAIR),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            cnt        <= '0;
            acc_q      <= '0;
            rdata_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        owner <= pick_winner;
                        if (pick_winner)
                            acc_q <= '{we: bus.m1_we, addr: bus.m1_addr, wdata: bus.m1_wdata};
                        else
                            acc_q <= '{we: bus.m0_we, addr: bus.m0_addr, wdata: bus.m0_wdata};
                        cnt   <= CNT_W'(ACC_CYCLES - 1);
                        state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        if (!acc_q.we) rdata_q <= bus.preaddata;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    last_owner <= owner;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Strobes only exist in ACCESS, so a reset edge clears them immediately.
    assign bus.pread      = (state == ST_ACCESS) && !acc_q.we;
    assign bus.pwrite     = (state == ST_ACCESS) &&  acc_q.we;
    assign bus.addr       = acc_q.addr;
    assign bus.pwritedata = acc_q.wdata;
    assign bus.rdata      = rdata_q;

    assign gnt_v  = onehot2(state != ST_IDLE, owner);
    assign done_v = onehot2(state == ST_DONE, owner);

    assign bus.m0_gnt  = gnt_v[0];
    assign bus.m1_gnt  = gnt_v[1];
    assign bus.m0_done = done_v[0];
    assign bus.m1_done = done_v[1];

endmodule
